// File: rtl/ham_pkg.sv
// Shared Hamming(15,11) types, parity-position table and encode helpers.
package ham_pkg;

  typedef logic [11:1] ham_data_t;
  typedef logic [15:1] ham_word_t;
  typedef logic [3:0]  ham_par_t;   // {p8,p4,p2,p1}

  localparam logic [3:0][3:0] HAM_PAR_POS = {4'd8, 4'd4, 4'd2, 4'd1};

  function automatic ham_par_t ham_parity(input ham_data_t d);
    ham_par_t p;
    p[0] = d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[9]  ^ d[11];
    p[1] = d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[7] ^ d[10] ^ d[11];
    p[2] = d[2] ^ d[3] ^ d[4] ^ d[8] ^ d[9] ^ d[10] ^ d[11];
    p[3] = d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[10] ^ d[11];
    return p;
  endfunction

  // Data occupies the non-power-of-two positions; parity drops into the table slots.
  function automatic ham_word_t ham_assemble(input ham_data_t d, input ham_par_t p);
    ham_word_t w;
    w = {d[11:5], 1'b0, d[4:2], 1'b0, d[1], 2'b00};
    for (int unsigned i = 0; i < 4; i++) begin
      w[HAM_PAR_POS[i]] = p[i];
    end
    return w;
  endfunction

  function automatic ham_word_t ham_flip_mask(input logic [3:0] pos);
    ham_word_t m;
    m = '0;
    if (pos != 4'd0) begin
      m[pos] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/ham_encode_comb.sv
// Purely combinational Hamming(15,11) encoder; also usable as a bench reference.
module ham_encode_comb
  import ham_pkg::*;
(
  input  logic [11:1] data,
  output logic [15:1] ham
);

  always_comb begin
    ham = ham_assemble(data, ham_parity(data));
  end

endmodule

// File: rtl/ham_encode_pipe.sv
// Two-stage streaming Hamming(15,11) encoder with valid/ready on both sides.
// Optional single-bit fault injection is enabled by defining HAM_ERR_INJECT_EN.
module ham_encode_pipe
  import ham_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [11:1]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [15:1]      out_ham,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] word_count
`ifdef HAM_ERR_INJECT_EN
  ,
  input  logic [3:0]       inj_pos
`endif
);

  ham_word_t enc;
  ham_data_t s1_data;
  ham_par_t  s1_par;
  logic      s1_valid;
  logic      s2_valid;
  logic      s1_adv;
  logic      s2_adv;
  ham_word_t s2_word;
`ifdef HAM_ERR_INJECT_EN
  logic [3:0] s1_inj;
`endif

  ham_encode_comb u_enc (
    .data (in_data),
    .ham  (enc)
  );

  always_comb begin
    s2_adv   = s1_valid & (~s2_valid | out_ready);
    s1_adv   = in_valid & (~s1_valid | s2_adv);
    in_ready = ~s1_valid | ~s2_valid | out_ready;
  end

  // Parity is taken from the clean encoding; injection only touches the S2 load.
  always_comb begin
`ifdef HAM_ERR_INJECT_EN
    s2_word = ham_assemble(s1_data, s1_par) ^ ham_flip_mask(s1_inj);
`else
    s2_word = ham_assemble(s1_data, s1_par);
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_par   <= '0;
`ifdef HAM_ERR_INJECT_EN
      s1_inj   <= '0;
`endif
    end else if (s1_adv) begin
      s1_valid <= 1'b1;
      s1_data  <= in_data;
      s1_par   <= {enc[8], enc[4], enc[2], enc[1]};
`ifdef HAM_ERR_INJECT_EN
      s1_inj   <= inj_pos;
`endif
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      out_ham  <= '0;
    end else if (s2_adv) begin
      s2_valid <= 1'b1;
      out_ham  <= s2_word;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word_count <= '0;
    end else if (s2_valid & out_ready) begin
      word_count <= word_count + 1'b1;
    end
  end

  assign out_valid = s2_valid;

endmodule

// File: tb/tb_ham_encode_pipe.sv
// Directed self-checking bench for ham_encode_pipe (16-bit and 4-bit counter instances).
module tb_ham_encode_pipe;

  logic        clock;
  logic        reset;
  logic [11:1] in_data;
  logic        in_valid;
  logic        in_ready, in_ready4;
  logic [15:1] out_ham, out_ham4;
  logic        out_valid, out_valid4;
  logic        out_ready;
  logic [15:0] word_count;
  logic [3:0]  word_count4;
  logic [3:0]  inj_pos;

  int checks = 0;
  int errors = 0;

  ham_encode_pipe #(.CNT_W(16)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_ham(out_ham), .out_valid(out_valid),
    .out_ready(out_ready), .word_count(word_count)
`ifdef HAM_ERR_INJECT_EN
    , .inj_pos(inj_pos)
`endif
  );

  ham_encode_pipe #(.CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready4), .out_ham(out_ham4), .out_valid(out_valid4),
    .out_ready(out_ready), .word_count(word_count4)
`ifdef HAM_ERR_INJECT_EN
    , .inj_pos(inj_pos)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Independent reference: scatter data, then each parity covers positions with its bit set.
  function automatic logic [15:1] model_enc(input logic [11:1] d);
    logic [15:1] w;
    int k;
    logic p;
    w = '0;
    k = 1;
    for (int pos = 1; pos <= 15; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        w[pos] = d[k];
        k++;
      end
    end
    for (int b = 0; b < 4; b++) begin
      p = 1'b0;
      for (int pos = 1; pos <= 15; pos++)
        if ((pos & (1 << b)) != 0) p = p ^ w[pos];
      w[1 << b] = p;
    end
    return w;
  endfunction

  function automatic logic [3:0] syndrome(input logic [15:1] w);
    logic [3:0] s;
    s = '0;
    for (int pos = 1; pos <= 15; pos++)
      if (w[pos]) s = s ^ 4'(pos);
    return s;
  endfunction

  function automatic logic [15:1] hamfix(input logic [15:1] w);
    logic [15:1] c;
    logic [3:0]  s;
    c = w;
    s = syndrome(w);
    if (s != 4'd0) c[s] = ~c[s];
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [11:1] kv_d [6];
  logic [15:1] kv_w [6];
  logic [15:1] hold_a, hold_b, hold_c;
  int bad_val, bad_vld, bad_syn, bad_rdy, stale;

  initial begin
    kv_d[0] = 11'h000; kv_w[0] = 15'h0000;
    kv_d[1] = 11'h7FF; kv_w[1] = 15'h7FFF;
    kv_d[2] = 11'h001; kv_w[2] = 15'h0007;
    kv_d[3] = 11'h002; kv_w[3] = 15'h0019;
    kv_d[4] = 11'h010; kv_w[4] = 15'h0181;
    kv_d[5] = 11'h400; kv_w[5] = 15'h408B;

    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; inj_pos = '0;
    #12;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_ham", 32'(out_ham), 0);
    check("rst_word_count", 32'(word_count), 0);
    tick();
    reset = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 1);

    // Known codewords, no stall
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = kv_d[i];
      check("kv_in_ready", 32'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      check("kv_valid_early", 32'(out_valid), 0);
      tick();
      check("kv_valid", 32'(out_valid), 1);
      check("kv_ham", 32'(out_ham), 32'(kv_w[i]));
      tick();
      check("kv_drained", 32'(out_valid), 0);
    end
    check("kv_count", 32'(word_count), 6);

    // Exhaustive back-to-back stream
    reset = 1'b1; #2; reset = 1'b0;
    tick();
    bad_val = 0; bad_vld = 0; bad_syn = 0; bad_rdy = 0;
    for (int j = 0; j < 2050; j++) begin
      if (j < 2048) begin
        in_valid = 1'b1; in_data = 11'(j);
        if (in_ready !== 1'b1) bad_rdy++;
      end else begin
        in_valid = 1'b0;
      end
      if (j >= 2) begin
        if (out_valid !== 1'b1) bad_vld++;
        if (out_ham !== model_enc(11'(j - 2))) bad_val++;
        if (syndrome(out_ham) !== 4'd0) bad_syn++;
      end
      tick();
    end
    check("stream_ready_gaps", 32'(bad_rdy), 0);
    check("stream_valid_gaps", 32'(bad_vld), 0);
    check("stream_value_errs", 32'(bad_val), 0);
    check("stream_hamfix_corrections", 32'(bad_syn), 0);
    check("stream_count", 32'(word_count), 2048);
    check("stream_count4", 32'(word_count4), 0);
    check("stream_drained", 32'(out_valid), 0);

    // Backpressure: three words against a 5-cycle stall
    reset = 1'b1; #2; reset = 1'b0;
    tick();
    hold_a = model_enc(11'h123); hold_b = model_enc(11'h456); hold_c = model_enc(11'h789);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 11'h123;
    tick();
    check("bp_ready_1buf", 32'(in_ready), 1);
    in_data = 11'h456;
    tick();
    in_data = 11'h789;
    for (int c = 0; c < 5; c++) begin
      check("bp_ready_full", 32'(in_ready), 0);
      check("bp_valid_hold", 32'(out_valid), 1);
      check("bp_ham_hold", 32'(out_ham), 32'(hold_a));
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_ready_release", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    check("bp_word2_valid", 32'(out_valid), 1);
    check("bp_word2", 32'(out_ham), 32'(hold_b));
    tick();
    check("bp_word3_valid", 32'(out_valid), 1);
    check("bp_word3", 32'(out_ham), 32'(hold_c));
    tick();
    check("bp_drained", 32'(out_valid), 0);
    check("bp_count", 32'(word_count), 3);

    // Counter wrap on the 4-bit instance
    reset = 1'b1; #2; reset = 1'b0;
    tick();
    for (int j = 0; j < 20; j++) begin
      in_valid = (j < 17);
      in_data  = 11'(j);
      if (j == 17) check("wrap_15", 32'(word_count4), 15);
      if (j == 18) check("wrap_0", 32'(word_count4), 0);
      if (j == 19) begin
        check("wrap_1", 32'(word_count4), 1);
        check("wrap_count16", 32'(word_count), 17);
      end
      tick();
    end

    // Reset with two words buffered
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 11'h0AA;
    tick();
    in_data = 11'h155;
    tick();
    in_valid = 1'b0;
    check("mr_buffered", 32'(in_ready), 0);
    check("mr_count_before", 32'(word_count), 17);
    #2;
    reset = 1'b1;
    #1;
    check("mr_out_valid", 32'(out_valid), 0);
    check("mr_count", 32'(word_count), 0);
    check("mr_count4", 32'(word_count4), 0);
    check("mr_out_ham", 32'(out_ham), 0);
    #2;
    reset = 1'b0;
    out_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (out_valid !== 1'b0) stale++;
    end
    check("mr_no_stale", 32'(stale), 0);
    check("mr_count_after", 32'(word_count), 0);

`ifdef HAM_ERR_INJECT_EN
    in_valid = 1'b1; in_data = 11'h000; inj_pos = 4'd5;
    tick();
    in_data = 11'h000; inj_pos = 4'd0;
    tick();
    in_data = 11'h7FF; inj_pos = 4'd15;
    check("inj5_ham", 32'(out_ham), 32'h0010);
    check("inj5_fix", 32'(hamfix(out_ham)), 32'h0000);
    tick();
    in_valid = 1'b0; inj_pos = 4'd0;
    check("inj0_ham", 32'(out_ham), 32'h0000);
    check("inj0_fix", 32'(hamfix(out_ham)), 32'h0000);
    tick();
    check("inj15_ham", 32'(out_ham), 32'h3FFF);
    check("inj15_fix", 32'(hamfix(out_ham)), 32'h7FFF);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: observed no finish expected finish before 500000");
    $fatal(1, "timeout");
  end

endmodule
